// File: rtl/conv_mac_pkg.sv
// Shared constants, helper function and pipeline stage records for conv_mac_sched.
// Contents:
//   DIN0_WIDTH / DIN1_WIDTH / PROD_WIDTH / ACC_WIDTH : default datapath widths
//   ID_MAX_WIDTH : tag width that covers the largest supported requester count (8)
//   clog2()      : ceiling log2 for parameter derivation
//   s1_t / s2_t  : operand stage and product stage records
package conv_mac_pkg;

  localparam int unsigned DIN0_WIDTH   = 16;
  localparam int unsigned DIN1_WIDTH   = 8;
  localparam int unsigned PROD_WIDTH   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned ACC_WIDTH    = 32;
  localparam int unsigned MAX_REQ      = 8;
  localparam int unsigned ID_MAX_WIDTH = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  typedef struct packed {
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic [ID_MAX_WIDTH-1:0]      id;
    logic                         last;
    logic                         v;
  } s1_t;

  typedef struct packed {
    logic signed [PROD_WIDTH-1:0] prod;
    logic [ID_MAX_WIDTH-1:0]      id;
    logic                         last;
    logic                         v;
  } s2_t;

endpackage

// File: rtl/conv_mac_sched_if.sv
// Requester and result handshake bundle for conv_mac_sched.
// Signals:
//   req_valid/req_ready/req_last [NUM_REQ]  per-requester handshake and end-of-stream flag
//   req_din0 [NUM_REQ*DIN0_WIDTH]            signed data, slice i belongs to requester i
//   req_din1 [NUM_REQ*DIN1_WIDTH]            signed coefficients, slice i belongs to requester i
//   res_valid/res_ready                      result handshake
//   res_id [ID_WIDTH], res_data [ACC_WIDTH]  tagged dot product
// Modports: master = requesters + result sink, slave = the scheduler.
interface conv_mac_sched_if
  import conv_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic [NUM_REQ-1:0]            req_last;
  logic                          res_valid;
  logic                          res_ready;
  logic [ID_WIDTH-1:0]           res_id;
  logic [ACC_WIDTH-1:0]          res_data;

  modport master (
    output req_valid, req_din0, req_din1, req_last, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_din0, req_din1, req_last, res_ready,
    output req_ready, res_valid, res_id, res_data
  );

endinterface

// File: rtl/conv_mul_core.sv
// Purely combinational signed multiplier, isolated so it maps onto a single DSP block.
// Ports:
//   i_din0 [DIN0_WIDTH]  signed data operand
//   i_din1 [DIN1_WIDTH]  signed coefficient
//   o_prod [PROD_WIDTH]  signed product
module conv_mul_core #(
  parameter int unsigned DIN0_WIDTH = 16,
  parameter int unsigned DIN1_WIDTH = 8,
  parameter int unsigned PROD_WIDTH = 24
) (
  input  logic signed [DIN0_WIDTH-1:0] i_din0,
  input  logic signed [DIN1_WIDTH-1:0] i_din1,
  output logic signed [PROD_WIDTH-1:0] o_prod
);

  // Both operands sign-extended to the full product width; the exact product always fits.
  assign o_prod = PROD_WIDTH'(i_din0) * PROD_WIDTH'(i_din1);

endmodule

// File: rtl/conv_mac_sched.sv
// Round-robin scheduler sharing one signed multiplier between NUM_REQ convolution requesters.
// Each requester streams operand pairs ending with a last flag; products are accumulated in a
// private per-requester accumulator and one tagged dot product is returned per stream.
// Ports:
//   ap_clk    sole clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   bus       conv_mac_sched_if slave: requester handshakes in, result handshake out
// Pipeline: arbiter -> S1 (operands) -> multiplier -> S2 (product) -> accumulate / output register.
module conv_mac_sched
  import conv_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  conv_mac_sched_if.slave bus
);

  // Accumulator array sized to the full tag range so any id indexes in bounds.
  localparam int unsigned NUM_ACC = 1 << ID_WIDTH;

  s1_t                         r_s1;
  s2_t                         r_s2;
  logic [ID_WIDTH-1:0]         r_rr;
  logic signed [ACC_WIDTH-1:0] r_acc [NUM_ACC];
  logic                        r_res_valid;
  logic [ID_WIDTH-1:0]         r_res_id;
  logic signed [ACC_WIDTH-1:0] r_res_data;

  logic [NUM_REQ-1:0]          w_grant;
  logic [ID_WIDTH-1:0]         w_gnt_id;
  logic [ID_WIDTH-1:0]         w_idx;
  logic                        w_gnt_any;
  logic                        w_s2_block;
  logic                        w_s1_free;
  logic                        w_xfer;
  logic signed [DIN0_WIDTH-1:0] w_din0;
  logic signed [DIN1_WIDTH-1:0] w_din1;
  logic                        w_last;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic [ID_WIDTH-1:0]         w_id;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_retire;

  // Round-robin search: first valid requester at or after r_rr wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_id  = '0;
    w_idx     = '0;
    w_gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((32'(r_rr) + k) % NUM_REQ);
      if (!w_gnt_any && bus.req_valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gnt_id       = w_idx;
        w_gnt_any      = 1'b1;
      end
    end
  end

  // Only a last entry facing a full, unaccepted output register can stall the pipe.
  assign w_s2_block = r_s2.v & r_s2.last & r_res_valid & ~bus.res_ready;
  assign w_s1_free  = ~r_s1.v | ~w_s2_block;
  assign w_xfer     = w_gnt_any & w_s1_free;

  assign bus.req_ready = w_grant & {NUM_REQ{w_s1_free & ap_rst_n}};

  assign w_din0 = bus.req_din0[32'(w_gnt_id)*DIN0_WIDTH +: DIN0_WIDTH];
  assign w_din1 = bus.req_din1[32'(w_gnt_id)*DIN1_WIDTH +: DIN1_WIDTH];
  assign w_last = bus.req_last[w_gnt_id];

  conv_mul_core #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .PROD_WIDTH(PROD_WIDTH)
  ) u_mul (
    .i_din0(r_s1.din0),
    .i_din1(r_s1.din1),
    .o_prod(w_prod)
  );

  assign w_id       = r_s2.id[ID_WIDTH-1:0];
  assign w_prod_ext = ACC_WIDTH'($signed(r_s2.prod));
  assign w_sum      = r_acc[w_id] + w_prod_ext;
  assign w_retire   = r_s2.v & ~w_s2_block;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr        <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_rr <= ID_WIDTH'((32'(w_gnt_id) + 1) % NUM_REQ);
      end

      if (w_s1_free) begin
        r_s1.v    <= w_xfer;
        r_s1.din0 <= w_din0;
        r_s1.din1 <= w_din1;
        r_s1.id   <= ID_MAX_WIDTH'(w_gnt_id);
        r_s1.last <= w_last;
      end

      if (!w_s2_block) begin
        r_s2.v    <= r_s1.v;
        r_s2.prod <= w_prod;
        r_s2.id   <= r_s1.id;
        r_s2.last <= r_s1.last;
      end

      // Accept frees the output register; a retiring last entry may refill it on the same edge.
      if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end

      if (w_retire) begin
        if (r_s2.last) begin
          r_res_valid  <= 1'b1;
          r_res_id     <= w_id;
          r_res_data   <= w_sum;
          r_acc[w_id]  <= '0;
        end else begin
          r_acc[w_id]  <= w_sum;
        end
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_data  = r_res_data;

endmodule

// File: tb/tb_conv_mac_sched.sv
module tb_conv_mac_sched;

  localparam int NUM_REQ = 4;

  typedef struct {
    logic signed [15:0] d0;
    logic signed [7:0]  d1;
    bit                 last;
  } pair_t;

  typedef struct {
    int id;
    int data;
  } exp_t;

  logic ap_clk;
  logic ap_rst_n;

  conv_mac_sched_if #(.NUM_REQ(NUM_REQ), .ID_WIDTH(2)) bus ();

  conv_mac_sched #(.NUM_REQ(NUM_REQ), .ID_WIDTH(2)) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int    n_checks = 0;
  int    n_fail   = 0;
  pair_t q [NUM_REQ][$];
  exp_t  sb[$];
  int    m_acc [NUM_REQ];
  int    acc_cnt [NUM_REQ];
  int    glog[$];
  int    rlog[$];
  int    cyc = 0;
  int    last_acc_cyc = 0;
  bit    lat_chk = 1'b0;
  bit    prev_valid = 1'b0;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_pair(input int r, input int d0, input int d1, input bit last);
    pair_t p;
    p.d0 = 16'(d0);
    p.d1 = 8'(d1);
    p.last = last;
    q[r].push_back(p);
  endtask

  function automatic bit busy();
    bit b;
    b = (sb.size() != 0);
    for (int i = 0; i < NUM_REQ; i++) if (q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (busy() && n < bound) begin
      @(negedge ap_clk);
      n++;
    end
    if (busy()) check_eq("drain_timeout", 1, 0);
    repeat (2) @(negedge ap_clk);
  endtask

  // Requester driver, model and result monitor; samples 1 time unit before each rising edge.
  logic [NUM_REQ-1:0] drv_w;
  pair_t              drv_p;
  exp_t               drv_e;
  initial begin
    bus.req_valid = '0;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_acc[i] = 0;
      acc_cnt[i] = 0;
    end
    forever begin
      @(negedge ap_clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() > 0) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_din0[i*16 +: 16] = q[i][0].d0;
          bus.req_din1[i*8 +: 8]   = q[i][0].d1;
          bus.req_last[i]          = q[i][0].last;
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      #4;
      cyc++;
      drv_w = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drv_w[i] && q[i].size() > 0) begin
          drv_p = q[i].pop_front();
          glog.push_back(i);
          acc_cnt[i]++;
          m_acc[i] = m_acc[i] + int'(drv_p.d0) * int'(drv_p.d1);
          if (drv_p.last) begin
            drv_e.id   = i;
            drv_e.data = m_acc[i];
            sb.push_back(drv_e);
            m_acc[i] = 0;
            last_acc_cyc = cyc;
          end
        end
      end
      if (lat_chk && bus.res_valid && !prev_valid) begin
        check_eq("latency", cyc - last_acc_cyc, 3);
        lat_chk = 1'b0;
      end
      prev_valid = bus.res_valid;
      if (bus.res_valid && bus.res_ready) begin
        rlog.push_back(cyc);
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          drv_e = sb.pop_front();
          check_eq("res_id", longint'(bus.res_id), drv_e.id);
          check_eq("res_data", longint'($signed(bus.res_data)), drv_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n0;
    int pos;
    ap_rst_n = 1'b0;
    bus.res_ready = 1'b1;
    #12;
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_id", bus.res_id, 0);
    check_eq("rst_res_data", bus.res_data, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Single stream with latency check: 100*3 - 5*7 = 265.
    lat_chk = 1'b1;
    push_pair(0, 100, 3, 1'b0);
    push_pair(0, -5, 7, 1'b1);
    wait_drain(50);
    check_eq("latency_seen", lat_chk, 0);
    check_eq("single_model", m_acc[0], 0);

    // Extremes on requester 3, which also leaves the pointer at 0.
    push_pair(3, -32768, -128, 1'b1);
    push_pair(3, -32768, 127, 1'b1);
    wait_drain(50);

    // Fairness between 0 and 2, then 3 joins late.
    glog.delete();
    for (int k = 0; k < 8; k++) begin
      push_pair(0, k + 1, 2, k == 7);
      push_pair(2, -k, 3, k == 7);
    end
    n = 0;
    while (glog.size() < 4 && n < 40) begin
      @(negedge ap_clk);
      n++;
    end
    if (glog.size() < 4) begin
      check_eq("fair_timeout", glog.size(), 4);
    end else begin
      check_eq("fair_g0", glog[0], 0);
      check_eq("fair_g1", glog[1], 2);
      check_eq("fair_g2", glog[2], 0);
      check_eq("fair_g3", glog[3], 2);
    end
    n0 = glog.size();
    push_pair(3, 9, 9, 1'b1);
    wait_drain(100);
    pos = -1;
    for (int j = n0; j < glog.size(); j++) if (pos < 0 && glog[j] == 3) pos = j;
    check_eq("req3_served", (pos >= 0) && (pos - n0 < NUM_REQ), 1);

    // Interleaved 3x3 kernels on requesters 1 and 3, then single pairs prove cleared sums.
    for (int k = 0; k < 9; k++) begin
      push_pair(1, int'($urandom_range(65535)) - 32768, int'($urandom_range(255)) - 128, k == 8);
      push_pair(3, int'($urandom_range(65535)) - 32768, int'($urandom_range(255)) - 128, k == 8);
    end
    wait_drain(100);
    push_pair(1, 7, -3, 1'b1);
    push_pair(3, 7, -3, 1'b1);
    wait_drain(50);

    // Backpressure with two last entries in flight.
    bus.res_ready = 1'b0;
    push_pair(0, 1000, 5, 1'b0);
    push_pair(0, -20, 9, 1'b1);
    push_pair(1, 300, -4, 1'b0);
    push_pair(1, 12, 12, 1'b1);
    for (int k = 0; k < 5; k++) push_pair(2, 50 + k, -1, k == 4);
    repeat (10) @(negedge ap_clk);
    #1;
    check_eq("bp_res_valid", bus.res_valid, 1);
    check_eq("bp_req_ready", bus.req_ready, 0);
    if (sb.size() < 2) begin
      check_eq("bp_sb_depth", sb.size(), 2);
    end else begin
      check_eq("bp_hold_id", bus.res_id, sb[0].id);
      check_eq("bp_hold_data", $signed(bus.res_data), sb[0].data);
    end
    repeat (3) @(negedge ap_clk);
    #1;
    if (sb.size() > 0) check_eq("bp_stable_data", $signed(bus.res_data), sb[0].data);
    rlog.delete();
    bus.res_ready = 1'b1;
    wait_drain(100);
    if (rlog.size() < 2) check_eq("bp_results", rlog.size(), 2);
    else check_eq("bp_back_to_back", rlog[1] - rlog[0], 1);

    // Reset mid-stream after 4 of 9 pairs.
    acc_cnt[2] = 0;
    for (int k = 0; k < 9; k++) push_pair(2, 400 + k, 7, k == 8);
    n = 0;
    while (acc_cnt[2] < 4 && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    check_eq("mid_accepts", acc_cnt[2], 4);
    #1;
    ap_rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      q[i].delete();
      m_acc[i] = 0;
    end
    sb.delete();
    #1;
    check_eq("mid_rst_res_valid", bus.res_valid, 0);
    check_eq("mid_rst_res_data", bus.res_data, 0);
    check_eq("mid_rst_res_id", bus.res_id, 0);
    check_eq("mid_rst_req_ready", bus.req_ready, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    rlog.delete();
    push_pair(2, 11, 5, 1'b0);
    push_pair(2, 2, -3, 1'b1);
    wait_drain(50);
    check_eq("post_rst_results", rlog.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
